// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the unified SRAM port arbiter: owner encoding and default widths.
package sram_arb_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of fetch, load/store and SRAM-side signals around the port arbiter.
interface sram_port_arbiter_if import sram_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter_starve_cnt.sv
// Counts consecutive data grants while a fetch is waiting; flags when fetch must win.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic starve_hit
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    // Saturating: holds at the limit until fetch is served or withdraws.
    always_ff @(posedge clk) begin
        if (reset || i_gnt || !i_req)
            cnt <= '0;
        else if (d_gnt && cnt != CW'(STARVE_MAX))
            cnt <= cnt + 1'b1;
    end

    assign starve_hit = (cnt == CW'(STARVE_MAX));
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency SRAM between fetch and load/store; data has priority
// unless fetch has been starved for STARVE_MAX grants.
module sram_port_arbiter import sram_arb_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.slave   bus
);
    logic              gnt_i, gnt_d, starve_hit;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    owner_e            owner, owner_nxt;

    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .i_req      (bus.i_req),
        .i_gnt      (gnt_i),
        .d_gnt      (gnt_d),
        .starve_hit (starve_hit)
    );

    always_comb begin
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        owner_nxt = OWN_NONE;
        if (!reset) begin
            if (bus.d_req && !(bus.i_req && starve_hit))
                gnt_d = 1'b1;
            else if (bus.i_req)
                gnt_i = 1'b1;
        end
        if (gnt_i) begin
            addr_mux  = bus.i_addr;
            owner_nxt = OWN_I;
        end else if (gnt_d) begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            owner_nxt = bus.d_we ? OWN_NONE : OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) owner <= OWN_NONE;
        else       owner <= owner_nxt;
    end

    assign bus.i_gnt      = gnt_i;
    assign bus.d_gnt      = gnt_d;
    assign bus.sram_en    = gnt_i | gnt_d;
    assign bus.sram_we    = gnt_d & bus.d_we;
    assign bus.sram_addr  = addr_mux;
    assign bus.sram_wdata = wdata_mux;

    // Gated by reset so a read in flight when reset rises is dropped immediately.
    assign bus.i_rvalid = (owner == OWN_I) && !reset;
    assign bus.d_rvalid = (owner == OWN_D) && !reset;
    assign bus.i_rdata  = bus.i_rvalid ? bus.sram_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.sram_rdata : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter against a behavioural model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // SRAM behavioural model (environment, 1-cycle read latency)
    logic [31:0] smem [logic [31:0]];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) smem[bus.sram_addr] = bus.sram_wdata;
            else bus.sram_rdata <= smem.exists(bus.sram_addr) ? smem[bus.sram_addr] : 32'h0;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    int          streak;        // data grants in a row while fetch waits
    int          pend_own;      // 0 none, 1 inst, 2 data: response due this cycle
    logic [31:0] pend_data;
    bit          last_gi, last_gd;
    logic        obs_dgnt;
    logic [31:0] obs_drdata;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit ir, logic [31:0] ia, bit dr, bit dw, logic [31:0] da, logic [31:0] dd);
        bus.i_req = ir; bus.i_addr = ia;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        bit eg_i, eg_d, ev_i, ev_d;
        logic [31:0] ea, ew;
        #1;
        eg_i = 0; eg_d = 0;
        if (!reset) begin
            if (bus.d_req && bus.i_req) begin
                if (streak == SMAX) eg_i = 1; else eg_d = 1;
            end else if (bus.d_req) eg_d = 1;
            else if (bus.i_req) eg_i = 1;
        end
        ea = eg_i ? bus.i_addr : (eg_d ? bus.d_addr : 32'h0);
        ew = eg_d ? bus.d_wdata : 32'h0;
        ev_i = !reset && pend_own == 1;
        ev_d = !reset && pend_own == 2;
        check("i_gnt",      32'(bus.i_gnt),    32'(eg_i));
        check("d_gnt",      32'(bus.d_gnt),    32'(eg_d));
        check("sram_en",    32'(bus.sram_en),  32'(eg_i | eg_d));
        check("sram_we",    32'(bus.sram_we),  32'(eg_d & bus.d_we));
        check("sram_addr",  bus.sram_addr,     ea);
        check("sram_wdata", bus.sram_wdata,    ew);
        check("i_rvalid",   32'(bus.i_rvalid), 32'(ev_i));
        check("d_rvalid",   32'(bus.d_rvalid), 32'(ev_d));
        check("i_rdata",    bus.i_rdata,       ev_i ? pend_data : 32'h0);
        check("d_rdata",    bus.d_rdata,       ev_d ? pend_data : 32'h0);
        obs_dgnt   = bus.d_gnt;
        obs_drdata = bus.d_rdata;
        @(posedge clk);
        if (reset) begin
            streak   = 0;
            pend_own = 0;
        end else begin
            pend_own = 0;
            if (eg_i) begin
                pend_own  = 1;
                pend_data = rd(bus.i_addr);
            end else if (eg_d) begin
                if (bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
                else begin
                    pend_own  = 2;
                    pend_data = rd(bus.d_addr);
                end
            end
            if (!bus.i_req || eg_i) streak = 0;
            else if (eg_d && streak < SMAX) streak++;
        end
        last_gi = eg_i;
        last_gd = eg_d;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] seq10;
        logic [4:0] seq5;
        streak = 0; pend_own = 0; pend_data = 0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smem[32'h1c000000 + 4*k]    = 32'ha0000000 + k;
            ref_mem[32'h1c000000 + 4*k] = 32'ha0000000 + k;
            smem[32'h104 + 4*k]         = 32'hb0000000 + k;
            ref_mem[32'h104 + 4*k]      = 32'hb0000000 + k;
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(); step();
        reset = 1'b0;

        // idle
        step(); step();

        // inst-only stream
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h1c000000 + 4*k, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();

        // write then read
        drive(0, 0, 1, 1, 32'h100, 32'hdeadbeef);
        step();
        drive(0, 0, 1, 0, 32'h100, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("wr_rd_data", obs_drdata, 32'hdeadbeef);

        // starvation bound
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h1c000004, 1, 0, 32'h104, 0);
            step();
            seq10[k] = obs_dgnt;
        end
        check("starve_seq", 32'(seq10), 32'(10'b0111101111));
        drive(0, 0, 0, 0, 0, 0);
        step();

        // starve clear: reach 3, fetch withdraws one cycle, then full window again
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h1c000008, 1, 0, 32'h108, 0);
            step();
        end
        drive(0, 0, 1, 0, 32'h108, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h1c000008, 1, 0, 32'h108, 0);
            step();
            seq5[k] = obs_dgnt;
        end
        check("clear_seq", 32'(seq5), 32'(5'b01111));
        drive(0, 0, 0, 0, 0, 0);
        step();

        // reset mid-read, requests held during reset
        drive(0, 0, 1, 0, 32'h10c, 0);
        step();
        reset = 1'b1;
        drive(1, 32'h1c000000, 1, 0, 32'h10c, 0);
        step(); step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();

        // randomized traffic, requesters hold until granted
        last_gi = 1; last_gd = 1;
        for (int c = 0; c < 400; c++) begin
            if (!bus.i_req || last_gi) begin
                bus.i_req  = ($urandom_range(0, 2) != 0);
                bus.i_addr = 32'h1c000000 + 4 * $urandom_range(0, 3);
            end
            if (!bus.d_req || last_gd) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = $urandom_range(0, 1) != 0;
                bus.d_addr  = 32'h100 + 4 * $urandom_range(0, 3);
                bus.d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
